// File: rtl/mult_job_arbiter.sv
// mult_job_arbiter
//   Arbitrates multiply jobs from two requesters onto one shared 16x9
//   sequential shift-add datapath. The block sequences the datapath through
//   one load cycle and YW step cycles. It then captures the accumulator and
//   returns the product over a valid/ack handshake to the requester that
//   owns the job.
//
//   Build option: define MULT_ARB_ROUND_ROBIN_EN for round-robin tie
//   breaking. Without it, requester 0 has fixed priority.
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   REQ_VALIDn/REQ_Xn/REQ_Yn     job request and operands from requester n
//   REQ_READYn                   one-cycle accept pulse to requester n
//   RSP_VALIDn/RSP_ACKn          response handshake for requester n
//   RSP_P                        registered product, shared by both requesters
//   MX_D, MY_D                   latched operands to the datapath
//   ACC_Q                        datapath accumulator contents
//   LOAD_MX..SHIFT_IN            datapath control strobes
//   BUSY                         high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting for a request, grant decided combinationally
// LOAD    | operands into MX/MY, accumulator cleared
// STEP    | YW shift-add steps, CNT counts them
// CAPTURE | accumulator copied into RSP_P
// RESP    | RSP_VALID to owner until owner's ACK
module mult_job_arbiter #(
    parameter int XW = 16,
    parameter int YW = 9,
    localparam int PW = XW + YW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID0,
    input  logic          REQ_VALID1,
    input  logic [XW-1:0] REQ_X0,
    input  logic [XW-1:0] REQ_X1,
    input  logic [YW-1:0] REQ_Y0,
    input  logic [YW-1:0] REQ_Y1,
    output logic          REQ_READY0,
    output logic          REQ_READY1,
    output logic          RSP_VALID0,
    output logic          RSP_VALID1,
    input  logic          RSP_ACK0,
    input  logic          RSP_ACK1,
    output logic [PW-1:0] RSP_P,
    output logic [XW-1:0] MX_D,
    output logic [YW-1:0] MY_D,
    input  logic [PW-1:0] ACC_Q,
    output logic          LOAD_MX,
    output logic          LOAD_MY,
    output logic          SHIFT_MY,
    output logic          CLEAR_ACC,
    output logic          LOAD_ACC,
    output logic          SHIFT_IN,
    output logic          BUSY
);

    localparam int CW = (YW > 1) ? $clog2(YW) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STEP    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          owner;
    logic [XW-1:0] op_x;
    logic [YW-1:0] op_y;
    logic [PW-1:0] rsp_p;
    logic          grant_id;
    logic          accept;
    logic          cnt_last;
    logic          ack_own;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    // rr_ptr names the requester preferred on a tie; it moves to the
    // requester that was not just granted.
    logic rr_ptr;

    always_comb begin
        grant_id = REQ_VALID1;
        if (REQ_VALID0 && REQ_VALID1) begin
            grant_id = rr_ptr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end
`else
    // Requester 0 wins whenever it is requesting.
    assign grant_id = ~REQ_VALID0;
`endif

    // Ready is combinational in IDLE so the accept happens at the edge that
    // ends the IDLE cycle; reset suppresses it so nothing is accepted while
    // RST is high.
    assign accept   = (state == S_IDLE) && (REQ_VALID0 || REQ_VALID1) && !RST;
    assign cnt_last = (cnt == CW'(YW - 1));
    assign ack_own  = owner ? RSP_ACK1 : RSP_ACK0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_STEP;
            S_STEP:    if (cnt_last) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    if (ack_own) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            owner <= 1'b0;
            op_x  <= '0;
            op_y  <= '0;
            rsp_p <= '0;
        end else begin
            if (accept) begin
                owner <= grant_id;
                op_x  <= grant_id ? REQ_X1 : REQ_X0;
                op_y  <= grant_id ? REQ_Y1 : REQ_Y0;
            end
            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_STEP) begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_CAPTURE) begin
                rsp_p <= ACC_Q;
            end
        end
    end

    always_comb begin
        LOAD_MX    = 1'b0;
        LOAD_MY    = 1'b0;
        CLEAR_ACC  = 1'b0;
        SHIFT_MY   = 1'b0;
        LOAD_ACC   = 1'b0;
        SHIFT_IN   = 1'b0;
        RSP_VALID0 = 1'b0;
        RSP_VALID1 = 1'b0;
        BUSY       = (state != S_IDLE);
        REQ_READY0 = accept && !grant_id;
        REQ_READY1 = accept && grant_id;
        case (state)
            S_LOAD: begin
                LOAD_MX   = 1'b1;
                LOAD_MY   = 1'b1;
                CLEAR_ACC = 1'b1;
            end
            S_STEP: begin
                SHIFT_MY = 1'b1;
                LOAD_ACC = 1'b1;
                SHIFT_IN = 1'b1;
            end
            S_RESP: begin
                RSP_VALID0 = !owner;
                RSP_VALID1 = owner;
            end
            default: ;
        endcase
    end

    assign MX_D  = op_x;
    assign MY_D  = op_y;
    assign RSP_P = rsp_p;

endmodule

// File: tb/tb_mult_job_arbiter.sv
module tb_mult_job_arbiter;

    localparam int XW = 16;
    localparam int YW = 9;
    localparam int PW = XW + YW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID0 = 1'b0, REQ_VALID1 = 1'b0;
    logic [XW-1:0] REQ_X0 = '0, REQ_X1 = '0;
    logic [YW-1:0] REQ_Y0 = '0, REQ_Y1 = '0;
    logic          REQ_READY0, REQ_READY1;
    logic          RSP_VALID0, RSP_VALID1;
    logic          RSP_ACK0 = 1'b0, RSP_ACK1 = 1'b0;
    logic [PW-1:0] RSP_P;
    logic [XW-1:0] MX_D;
    logic [YW-1:0] MY_D;
    logic [PW-1:0] ACC_Q;
    logic          LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN, BUSY;
    logic [5:0]    strb;

    int total = 0;
    int bad = 0;
    int n_load = 0, n_step = 0, n_ovl = 0;

    mult_job_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID0(REQ_VALID0), .REQ_VALID1(REQ_VALID1),
        .REQ_X0(REQ_X0), .REQ_X1(REQ_X1), .REQ_Y0(REQ_Y0), .REQ_Y1(REQ_Y1),
        .REQ_READY0(REQ_READY0), .REQ_READY1(REQ_READY1),
        .RSP_VALID0(RSP_VALID0), .RSP_VALID1(RSP_VALID1),
        .RSP_ACK0(RSP_ACK0), .RSP_ACK1(RSP_ACK1),
        .RSP_P(RSP_P), .MX_D(MX_D), .MY_D(MY_D), .ACC_Q(ACC_Q),
        .LOAD_MX(LOAD_MX), .LOAD_MY(LOAD_MY), .SHIFT_MY(SHIFT_MY),
        .CLEAR_ACC(CLEAR_ACC), .LOAD_ACC(LOAD_ACC), .SHIFT_IN(SHIFT_IN),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    assign strb = {LOAD_MX, LOAD_MY, CLEAR_ACC, SHIFT_MY, LOAD_ACC, SHIFT_IN};

    // Behavioural shift-add datapath: MSB-first multiplier, accumulator
    // doubles each step and adds MX when the current multiplier bit is set.
    logic [XW-1:0] dp_mx = '0;
    logic [YW-1:0] dp_my = '0;
    logic [PW-1:0] dp_acc = '0;

    always @(posedge CLK) begin
        if (LOAD_MX) dp_mx <= MX_D;
        if (LOAD_MY) dp_my <= MY_D;
        else if (SHIFT_MY) dp_my <= dp_my << 1;
        if (CLEAR_ACC) dp_acc <= '0;
        else if (LOAD_ACC && SHIFT_IN)
            dp_acc <= (dp_acc << 1) + (dp_my[YW-1] ? PW'(dp_mx) : PW'(0));
    end
    assign ACC_Q = dp_acc;

    always @(negedge CLK) begin
        if (LOAD_MX | LOAD_MY | CLEAR_ACC) n_load++;
        if (SHIFT_MY | LOAD_ACC | SHIFT_IN) n_step++;
        if ((LOAD_MX | LOAD_MY | CLEAR_ACC) && (SHIFT_MY | LOAD_ACC | SHIFT_IN)) n_ovl++;
    end

    task automatic set_req(input int id, input logic v, input logic [XW-1:0] x, input logic [YW-1:0] y);
        if (id == 0) begin
            REQ_VALID0 = v; REQ_X0 = x; REQ_Y0 = y;
        end else begin
            REQ_VALID1 = v; REQ_X1 = x; REQ_Y1 = y;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Runs one job from grant to the IDLE cycle after ACK. Entered at
    // negedge+1 with requests already driven; returns at negedge+1 of the
    // first IDLE cycle.
    task automatic run_job(input int exp_id, input int hold, input bit ack_other,
                           input bit [1:0] drop_mask, input bit scramble,
                           output int gid, output int waited);
        logic [XW-1:0] jx;
        logic [YW-1:0] jy;
        logic [PW-1:0] exp_p;
        int l0, s0, o0, n;
        bit rdy_seen;
        n = 0;
        while (!(REQ_READY0 || REQ_READY1) && n < 60) begin
            @(negedge CLK); #1; n++;
        end
        waited = n;
        gid = -1;
        total++;
        if (!(REQ_READY0 ^ REQ_READY1)) begin
            bad++;
            $display("FAIL grant_onehot: ready0=%0b ready1=%0b, want exactly one", REQ_READY0, REQ_READY1);
            return;
        end
        gid = REQ_READY1 ? 1 : 0;
        if (exp_id >= 0) begin
            total++;
            if (gid != exp_id) begin
                bad++;
                $display("FAIL grant_id: got %0d want %0d", gid, exp_id);
            end
        end
        jx = gid ? REQ_X1 : REQ_X0;
        jy = gid ? REQ_Y1 : REQ_Y0;
        exp_p = PW'(jx) * PW'(jy);
        l0 = n_load; s0 = n_step; o0 = n_ovl;
        rdy_seen = 0;

        @(negedge CLK);
        if (drop_mask[gid]) begin
            if (gid == 0) REQ_VALID0 = 1'b0; else REQ_VALID1 = 1'b0;
        end
        if (scramble) begin
            if (gid == 0) begin
                REQ_X0 = XW'($urandom_range(1, 65535)); REQ_Y0 = YW'($urandom_range(1, 511));
            end else begin
                REQ_X1 = XW'($urandom_range(1, 65535)); REQ_Y1 = YW'($urandom_range(1, 511));
            end
        end
        #1;
        total++;
        if (strb !== 6'b111000) begin
            bad++; $display("FAIL load_strobes: got %b want 111000", strb);
        end
        total++;
        if (MX_D !== jx || MY_D !== jy) begin
            bad++; $display("FAIL load_operands: got %h/%h want %h/%h", MX_D, MY_D, jx, jy);
        end
        total++;
        if (BUSY !== 1'b1) begin
            bad++; $display("FAIL busy_load: got %b want 1", BUSY);
        end
        rdy_seen |= REQ_READY0 | REQ_READY1;

        for (int c = 0; c < YW; c++) begin
            @(negedge CLK); #1;
            total++;
            if (strb !== 6'b000111 || MX_D !== jx) begin
                bad++; $display("FAIL step_cycle%0d: strobes %b mx %h want 000111 mx %h", c, strb, MX_D, jx);
            end
            rdy_seen |= REQ_READY0 | REQ_READY1;
        end

        @(negedge CLK); #1;
        total++;
        if (strb !== 6'b0 || BUSY !== 1'b1 || {RSP_VALID1, RSP_VALID0} !== 2'b00) begin
            bad++; $display("FAIL capture_cycle: strobes %b busy %b rsp_valid %b%b want 000000 1 00",
                            strb, BUSY, RSP_VALID1, RSP_VALID0);
        end
        rdy_seen |= REQ_READY0 | REQ_READY1;

        @(negedge CLK); #1;
        total++;
        if ({RSP_VALID1, RSP_VALID0} !== (gid ? 2'b10 : 2'b01) || strb !== 6'b0) begin
            bad++; $display("FAIL rsp_valid: got %b%b strobes %b want owner %0d only, no strobes",
                            RSP_VALID1, RSP_VALID0, strb, gid);
        end
        total++;
        if (RSP_P !== exp_p) begin
            bad++; $display("FAIL rsp_product: got %h want %h", RSP_P, exp_p);
        end

        for (int h = 0; h < hold; h++) begin
            if (ack_other) begin
                if (gid == 0) RSP_ACK1 = 1'b1; else RSP_ACK0 = 1'b1;
            end
            @(negedge CLK); #1;
            total++;
            if ({RSP_VALID1, RSP_VALID0} !== (gid ? 2'b10 : 2'b01) || RSP_P !== exp_p || BUSY !== 1'b1) begin
                bad++; $display("FAIL rsp_hold%0d: valid %b%b p %h busy %b want owner %0d p %h busy 1",
                                h, RSP_VALID1, RSP_VALID0, RSP_P, BUSY, gid, exp_p);
            end
            rdy_seen |= REQ_READY0 | REQ_READY1;
        end
        if (gid == 0) RSP_ACK0 = 1'b1; else RSP_ACK1 = 1'b1;
        @(negedge CLK);
        RSP_ACK0 = 1'b0;
        RSP_ACK1 = 1'b0;
        #1;
        total++;
        if (BUSY !== 1'b0 || {RSP_VALID1, RSP_VALID0} !== 2'b00 || strb !== 6'b0) begin
            bad++; $display("FAIL back_to_idle: busy %b valid %b%b strobes %b want 0 00 000000",
                            BUSY, RSP_VALID1, RSP_VALID0, strb);
        end
        total++;
        if (rdy_seen) begin
            bad++; $display("FAIL ready_while_busy: got 1 want 0");
        end
        total++;
        if (n_load - l0 != 1 || n_step - s0 != YW || n_ovl - o0 != 0) begin
            bad++; $display("FAIL strobe_counts: load %0d step %0d overlap %0d want 1 %0d 0",
                            n_load - l0, n_step - s0, n_ovl - o0, YW);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        total++;
        if ({strb, REQ_READY0, REQ_READY1, RSP_VALID0, RSP_VALID1, BUSY} !== 11'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want all zero",
                            {strb, REQ_READY0, REQ_READY1, RSP_VALID0, RSP_VALID1, BUSY});
        end
        total++;
        if (RSP_P !== '0 || MX_D !== '0 || MY_D !== '0) begin
            bad++; $display("FAIL reset_data: p %h mx %h my %h want 0", RSP_P, MX_D, MY_D);
        end
        RST = 1'b0;
        @(negedge CLK); #1;
        total++;
        if (BUSY !== 1'b0 || strb !== 6'b0) begin
            bad++; $display("FAIL idle_after_reset: busy %b strobes %b want 0", BUSY, strb);
        end
    endtask

    task automatic test_req0();
        int gid, w;
        @(negedge CLK);
        set_req(0, 1'b1, 16'h1234, 9'h0AB);
        #1;
        run_job(0, 0, 1'b0, 2'b11, 1'b0, gid, w);
    endtask

    task automatic test_req1_hold();
        int gid, w;
        set_req(1, 1'b1, 16'hFFFF, 9'h1FF);
        #1;
        run_job(1, 5, 1'b1, 2'b11, 1'b0, gid, w);
    endtask

    task automatic test_zero_operand_latch();
        int gid, w;
        set_req(0, 1'b1, 16'h0000, 9'h1FF);
        #1;
        run_job(0, 1, 1'b0, 2'b11, 1'b1, gid, w);
    endtask

    task automatic test_random();
        int gid, w, id;
        for (int k = 0; k < 8; k++) begin
            id = int'($urandom_range(0, 1));
            REQ_VALID0 = 1'b0;
            REQ_VALID1 = 1'b0;
            set_req(id, 1'b1, XW'($urandom), YW'($urandom));
            #1;
            run_job(id, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 2'b11, 1'b0, gid, w);
            if (gid < 0) return;
        end
    endtask

    task automatic test_arbitration();
        int rem [2];
        int last, exp_id, gid, w;
        bit [1:0] dm;
        bit rr;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        do_reset();
        rem[0] = 3; rem[1] = 3;
        last = 1;
        set_req(0, 1'b1, XW'($urandom), YW'($urandom));
        set_req(1, 1'b1, XW'($urandom), YW'($urandom));
        #1;
        for (int k = 0; k < 6; k++) begin
            if (rem[0] > 0 && rem[1] > 0) exp_id = rr ? (1 - last) : 0;
            else exp_id = (rem[0] > 0) ? 0 : 1;
            dm = {rem[1] == 1, rem[0] == 1};
            run_job(exp_id, int'($urandom_range(0, 2)), 1'b0, dm, 1'b1, gid, w);
            if (gid < 0) return;
            if (k > 0) begin
                total++;
                if (w != 0) begin
                    bad++; $display("FAIL job_spacing: waited %0d idle cycles want 0", w);
                end
            end
            rem[gid] = rem[gid] - 1;
            last = gid;
        end
    endtask

    task automatic test_reset_mid_job();
        int n;
        bit seen;
        @(negedge CLK);
        set_req(0, 1'b1, 16'hBEEF, 9'h155);
        #1;
        n = 0;
        while (!REQ_READY0 && n < 40) begin
            @(negedge CLK); #1; n++;
        end
        total++;
        if (!REQ_READY0) begin
            bad++; $display("FAIL midjob_grant: ready0 %b want 1", REQ_READY0);
            REQ_VALID0 = 1'b0;
            return;
        end
        @(negedge CLK);
        REQ_VALID0 = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        total++;
        if (strb !== 6'b000111) begin
            bad++; $display("FAIL midjob_in_step: strobes %b want 000111", strb);
        end
        RST = 1'b1;
        @(negedge CLK); #1;
        total++;
        if (BUSY !== 1'b0 || strb !== 6'b0 || {RSP_VALID1, RSP_VALID0} !== 2'b00 || MX_D !== '0) begin
            bad++; $display("FAIL midjob_abort: busy %b strobes %b valid %b%b mx %h want 0 000000 00 0",
                            BUSY, strb, RSP_VALID1, RSP_VALID0, MX_D);
        end
        RST = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK); #1;
            seen |= RSP_VALID0 | RSP_VALID1 | BUSY;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midjob_no_response: activity 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_req0();
        test_req1_hold();
        test_zero_operand_latch();
        test_random();
        test_arbitration();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_job_arbiter.md
# mult_job_arbiter

Scheduler and sequencer for the shared 16x9 sequential shift-add multiplier datapath. It accepts multiply jobs from two requesters and arbitrates between them. For the granted job it drives operands and the six datapath control strobes through one load cycle and YW step cycles. It then captures the accumulator and returns the product over a valid/ack response handshake. Hardwired FSM; replaces table-driven sequencing when more than one client shares the multiplier.

## Interface
Parameters:
- XW, 16, multiplicand width (MX register)
- YW, 9, multiplier width (MY register); also the number of step cycles
- Product width PW = XW+YW (25 at defaults), derived, not overridable

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID0 / REQ_VALID1  in  1  job request from requester 0 / 1
- REQ_X0 / REQ_X1  in  XW  multiplicand, valid while REQ_VALIDn high
- REQ_Y0 / REQ_Y1  in  YW  multiplier, valid while REQ_VALIDn high
- REQ_READY0 / REQ_READY1  out  1  one-cycle accept pulse
- RSP_VALID0 / RSP_VALID1  out  1  product for requester n is on RSP_P
- RSP_ACK0 / RSP_ACK1  in  1  requester n consumes the response
- RSP_P  out  PW  registered product, shared by both requesters
- MX_D  out  XW  operand to datapath MX register
- MY_D  out  YW  operand to datapath MY register
- ACC_Q  in  PW  datapath accumulator contents
- LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN  out  1 each  datapath control strobes
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, STEP, CAPTURE, RESP. The step counter CNT has width clog2(YW).
- IDLE:
  - Evaluate REQ_VALID0/1 and pick a grant per the arbitration rule.
  - On grant n: pulse REQ_READYn, latch REQ_Xn/REQ_Yn into internal operand registers, record owner ID, go to LOAD.
  - No request: stay.
- LOAD: assert LOAD_MX, LOAD_MY, CLEAR_ACC; MX_D/MY_D show the latched operands; CNT<=0; go to STEP.
- STEP: assert SHIFT_MY, LOAD_ACC, SHIFT_IN; CNT increments; after the step with CNT==YW-1, go to CAPTURE.
- CAPTURE: RSP_P<=ACC_Q; go to RESP. No strobes asserted.
- RESP: RSP_VALID[owner]=1 and RSP_P held stable until RSP_ACK[owner] is sampled high, then go to IDLE.
  - The other requester's ACK is ignored.
  - New requests are not accepted during RESP.
- Strobes are Moore-decoded from the state register only. At most one of the LOAD group or the STEP group is active in any cycle.
- Operand registers change only on accept. MX_D/MY_D hold their last values outside LOAD.
- REQ_VALIDn dropping before grant: no job, no state change. Requesters must not drop REQ_VALIDn once raised until REQ_READYn.
- Arithmetic: the product is whatever the datapath accumulates. The block does no arithmetic beyond CNT, and does no truncation or extension of ACC_Q.

## Timing
- Reset (RST sampled high): state IDLE, CNT=0, all strobes 0, REQ_READY0/1=0, RSP_VALID0/1=0, RSP_P=0, MX_D=0, MY_D=0, BUSY=0, round-robin pointer points to requester 0.
- Reset mid-job aborts immediately. No response is issued for the aborted job.
- Accept at edge E0 (IDLE). The block then runs:
  - LOAD in cycle 1
  - STEP in cycles 2..YW+1 (9 cycles at default)
  - CAPTURE in cycle YW+2
  - RSP_VALID high from cycle YW+3
- Minimum job-to-job spacing at default: 13 cycles when ACK arrives in the first RESP cycle.
- ACK already high on RSP_VALID's first cycle is legal: RESP lasts exactly 1 cycle.
- After leaving RESP, IDLE lasts at least 1 cycle before the next REQ_READY.
- Simultaneous REQ_VALID0 and REQ_VALID1 in IDLE: resolved per Configuration. The loser keeps waiting and is granted in the next IDLE.

## Configuration
- Macro MULT_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On a tie, grant the requester not granted last; the pointer updates on every accept.
- Undefined: fixed priority, requester 0 always wins ties. The pointer logic is absent.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset then idle: all outputs 0, BUSY=0. Assert RST during STEP cycle 5: the next cycle is IDLE, no RSP_VALID, all strobes 0.
- Requester 0 sends X=0x1234, Y=0x0AB with a behavioural datapath model:
  - REQ_READY0 at E0, LOAD strobes in cycle 1, 9 STEP cycles
  - RSP_VALID0 in cycle 12 with RSP_P=0x0C28BC; ACK in cycle 12 returns to IDLE
- Requester 1 sends X=0xFFFF, Y=0x1FF: RSP_P=0x1FEFE01, RSP_VALID1 only. ACK0 asserted during RESP is ignored; hold for 5 cycles, then ACK1 clears.
- Both requesters valid continuously, three jobs each:
  - with the macro, grants alternate 0,1,0,1,0,1
  - without it, grants are 0,0,0, then 1,1,1 once requester 0 drops
- Strobe check across all jobs:
  - LOAD_MX/LOAD_MY/CLEAR_ACC high exactly 1 cycle per job, never overlapping SHIFT_MY/LOAD_ACC/SHIFT_IN
  - the STEP group is high exactly YW cycles
- X=0, Y=0x1FF yields RSP_P=0. Changing REQ_X0 after REQ_READY0 does not alter MX_D or the result.
